mem_arbiter: RTL and testbench

- Shares the single main-memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Sequences each access as a request/ready transaction and returns read data to the requester.
- Stalls fetch while its access is pending.
- Data has priority, with an anti-starvation limit for fetch, plus a watchdog timeout that flags a hung memory.

---
 rtl/mem_arbiter_pkg.sv | 37 +++
 rtl/mem_arb_watchdog.sv | 37 +++
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory-port arbiter: access sizes,
// arbiter states, sticky error codes and the default instruction base.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } access_size_e;

  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_F = 2'b01,
    BUSY_D = 2'b10
  } arb_state_e;

  localparam logic [1:0] ERR_NONE         = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT      = 2'b01;
  localparam logic [1:0] ERR_MISALIGNED   = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL_SIZE = 2'b11;

  localparam logic [31:0] INSTR_BASE_DEFAULT = 32'h8002_0000;

  function automatic logic is_misaligned(input logic [31:0] addr, input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_WORD: bad = (addr[1:0] != 2'b00);
      SIZE_HALF: bad = addr[0];
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog: counts enabled cycles and flags the last allowed
// cycle so the arbiter can abort a hung memory access.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clr_in,
  input  logic en_in,
  output logic expired_out
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_in) begin
      cnt_d = '0;
    end else if (en_in && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign expired_out = en_in && (cnt_q == LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between instruction fetch and the
// data stage: data-priority with a fetch anti-starvation streak, pre-issue
// legality checks, and a watchdog abort with a sticky error code.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter logic [31:0] INSTR_BASE      = INSTR_BASE_DEFAULT
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        f_req_in,
  input  logic [31:0] f_addr_in,
  output logic        f_done_out,
  output logic [31:0] f_rdata_out,
  output logic        stall_fetch_out,
  input  logic        d_req_in,
  input  logic [31:0] d_addr_in,
  input  logic        d_rw_in,
  input  logic [1:0]  d_access_size_in,
  input  logic [31:0] d_wdata_in,
  output logic        d_done_out,
  output logic [31:0] d_rdata_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  output logic        mem_rw_out,
  output logic [1:0]  mem_access_size_out,
  output logic [31:0] mem_wdata_out,
  input  logic        mem_ready_in,
  input  logic [31:0] mem_rdata_in,
  output logic        err_out,
  output logic [1:0]  err_code_out
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                mem_rw_q, mem_rw_d;
  logic [1:0]          mem_size_q, mem_size_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                f_done_q, f_done_d;
  logic [31:0]         f_rdata_q, f_rdata_d;
  logic                d_done_q, d_done_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic       data_wins;
  logic [1:0] fault_code;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_expired;

  // Counter restarts on every completion so each access gets a full budget.
  assign wd_en  = (state_q != IDLE);
  assign wd_clr = (state_q == IDLE) || mem_ready_in || wd_expired;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_in     (clk_in),
    .rst_n_in   (reset_n_in),
    .clr_in     (wd_clr),
    .en_in      (wd_en),
    .expired_out(wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_rw_d    = mem_rw_q;
    mem_size_d  = mem_size_q;
    mem_wdata_d = mem_wdata_q;
    f_done_d    = 1'b0;
    f_rdata_d   = '0;
    d_done_d    = 1'b0;
    d_rdata_d   = '0;
    err_d       = err_q;
    err_code_d  = err_code_q;
    fault_code  = ERR_NONE;
    data_wins   = d_req_in && (!f_req_in || (streak_q != STREAK_MAX));

    unique case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (data_wins) begin
          // A data win with fetch waiting implies streak < max, so no overflow.
          streak_d = f_req_in ? (streak_q + STREAK_W'(1)) : '0;
          if (d_access_size_in == SIZE_ILLEGAL) begin
            fault_code = ERR_ILLEGAL_SIZE;
          end else if (is_misaligned(d_addr_in, d_access_size_in)) begin
            fault_code = ERR_MISALIGNED;
          end
          if (fault_code != ERR_NONE) begin
            d_done_d = 1'b1;
          end else begin
            mem_req_d   = 1'b1;
            mem_addr_d  = d_addr_in;
            mem_rw_d    = d_rw_in;
            mem_size_d  = d_access_size_in;
            mem_wdata_d = d_wdata_in;
            state_d     = BUSY_D;
          end
        end else if (f_req_in) begin
          streak_d = '0;
          if (is_misaligned(f_addr_in, SIZE_WORD) || (f_addr_in < INSTR_BASE)) begin
            fault_code = ERR_MISALIGNED;
            f_done_d   = 1'b1;
          end else begin
            mem_req_d   = 1'b1;
            mem_addr_d  = f_addr_in;
            mem_rw_d    = 1'b0;
            mem_size_d  = SIZE_WORD;
            mem_wdata_d = '0;
            state_d     = BUSY_F;
          end
        end
      end

      BUSY_F, BUSY_D: begin
        if (mem_ready_in) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (state_q == BUSY_F) begin
            f_done_d  = 1'b1;
            f_rdata_d = mem_rdata_in;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = mem_rw_q ? '0 : mem_rdata_in;
          end
        end else if (wd_expired) begin
          mem_req_d  = 1'b0;
          state_d    = IDLE;
          fault_code = ERR_TIMEOUT;
          if (state_q == BUSY_F) begin
            f_done_d = 1'b1;
          end else begin
            d_done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // First error wins; later faults only keep the flag set.
    if (fault_code != ERR_NONE) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_code_d = fault_code;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rw_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_wdata_q <= '0;
      f_done_q    <= 1'b0;
      f_rdata_q   <= '0;
      d_done_q    <= 1'b0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_rw_q    <= mem_rw_d;
      mem_size_q  <= mem_size_d;
      mem_wdata_q <= mem_wdata_d;
      f_done_q    <= f_done_d;
      f_rdata_q   <= f_rdata_d;
      d_done_q    <= d_done_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign f_done_out          = f_done_q;
  assign f_rdata_out         = f_rdata_q;
  assign stall_fetch_out     = f_req_in & ~f_done_q;
  assign d_done_out          = d_done_q;
  assign d_rdata_out         = d_rdata_q;
  assign mem_req_out         = mem_req_q;
  assign mem_addr_out        = mem_addr_q;
  assign mem_rw_out          = mem_rw_q;
  assign mem_access_size_out = mem_size_q;
  assign mem_wdata_out       = mem_wdata_q;
  assign err_out             = err_q;
  assign err_code_out        = err_code_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle comparison against a
// transaction-level reference model, a vector table, directed corner cases
// and a randomized two-requester run.
module tb_mem_arbiter;

  localparam int          MAX_STREAK = 4;
  localparam int          TIMEOUT    = 64;
  localparam logic [31:0] IBASE      = 32'h8002_0000;

  logic        clk_in, reset_n_in;
  logic        f_req_in, f_done_out, stall_fetch_out;
  logic [31:0] f_addr_in, f_rdata_out;
  logic        d_req_in, d_rw_in, d_done_out;
  logic [31:0] d_addr_in, d_wdata_in, d_rdata_out;
  logic [1:0]  d_access_size_in;
  logic        mem_req_out, mem_rw_out, mem_ready_in;
  logic [31:0] mem_addr_out, mem_wdata_out, mem_rdata_in;
  logic [1:0]  mem_access_size_out;
  logic        err_out;
  logic [1:0]  err_code_out;

  mem_arbiter #(
    .MAX_DATA_STREAK(MAX_STREAK),
    .TIMEOUT_CYCLES (TIMEOUT),
    .INSTR_BASE     (IBASE)
  ) dut (
    .clk_in             (clk_in),
    .reset_n_in         (reset_n_in),
    .f_req_in           (f_req_in),
    .f_addr_in          (f_addr_in),
    .f_done_out         (f_done_out),
    .f_rdata_out        (f_rdata_out),
    .stall_fetch_out    (stall_fetch_out),
    .d_req_in           (d_req_in),
    .d_addr_in          (d_addr_in),
    .d_rw_in            (d_rw_in),
    .d_access_size_in   (d_access_size_in),
    .d_wdata_in         (d_wdata_in),
    .d_done_out         (d_done_out),
    .d_rdata_out        (d_rdata_out),
    .mem_req_out        (mem_req_out),
    .mem_addr_out       (mem_addr_out),
    .mem_rw_out         (mem_rw_out),
    .mem_access_size_out(mem_access_size_out),
    .mem_wdata_out      (mem_wdata_out),
    .mem_ready_in       (mem_ready_in),
    .mem_rdata_in       (mem_rdata_in),
    .err_out            (err_out),
    .err_code_out       (err_code_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // memory responder controls
  int lat = 1;
  bit hang = 0, late_ready = 0, rand_lat = 0;
  int resp_cnt = 0;

  // reference model state and expected outputs
  int          m_owner;   // 0 none, 1 fetch, 2 data
  int          m_streak, m_wait;
  bit          m_err;
  logic [1:0]  m_code;
  logic        e_mreq, e_mrw, e_fdone, e_ddone;
  logic [31:0] e_maddr, e_mwdata, e_frd, e_drd;
  logic [1:0]  e_msize;

  bit prev_mreq = 0;
  bit glog[$];
  int mreq_cycles = 0;

  typedef struct {
    bit          is_f;
    logic [31:0] addr;
    bit          rw;
    logic [1:0]  size;
    bit          exp_issue;
    logic [1:0]  exp_code;
  } vec_t;
  vec_t vecs[11];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [1:0] data_fault(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'b11) return 2'b11;
    if (s == 2'b10 && (a % 4) != 0) return 2'b10;
    if (s == 2'b01 && (a % 2) != 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_streak = 0; m_wait = 0; m_err = 0; m_code = 2'b00;
    e_mreq = 0; e_mrw = 0; e_fdone = 0; e_ddone = 0;
    e_maddr = '0; e_mwdata = '0; e_frd = '0; e_drd = '0; e_msize = '0;
  endtask

  task automatic raise(input logic [1:0] c);
    if (!m_err) m_code = c;
    m_err = 1;
  endtask

  task automatic finish_access(input logic [31:0] w);
    e_mreq = 0;
    if (m_owner == 1) begin e_fdone = 1; e_frd = w; end
    else begin e_ddone = 1; e_drd = w; end
    m_owner = 0;
  endtask

  // Predicts the outputs after the next edge from the inputs held this cycle.
  task automatic model_step();
    logic [1:0] c;
    if (!reset_n_in) begin
      model_reset();
      return;
    end
    e_fdone = 0; e_ddone = 0; e_frd = '0; e_drd = '0;
    if (m_owner == 0) begin
      e_mreq = 0;
      if (d_req_in && (!f_req_in || m_streak < MAX_STREAK)) begin
        m_streak = f_req_in ? m_streak + 1 : 0;
        c = data_fault(d_addr_in, d_access_size_in);
        if (c != 2'b00) begin
          raise(c);
          e_ddone = 1;
        end else begin
          e_mreq = 1; e_maddr = d_addr_in; e_mrw = d_rw_in;
          e_msize = d_access_size_in; e_mwdata = d_wdata_in;
          m_owner = 2; m_wait = 0;
        end
      end else if (f_req_in) begin
        m_streak = 0;
        if (f_addr_in < IBASE || (f_addr_in % 4) != 0) begin
          raise(2'b10);
          e_fdone = 1;
        end else begin
          e_mreq = 1; e_maddr = f_addr_in; e_mrw = 0;
          e_msize = 2'b10; e_mwdata = '0;
          m_owner = 1; m_wait = 0;
        end
      end
    end else if (mem_ready_in) begin
      finish_access((m_owner == 2 && e_mrw) ? 32'h0 : mem_word(e_maddr));
    end else if (m_wait == TIMEOUT - 1) begin
      raise(2'b01);
      finish_access(32'h0);
    end else begin
      m_wait++;
    end
  endtask

  task automatic respond();
    if (mem_req_out && !hang) begin
      if (rand_lat && resp_cnt == 0) lat = $urandom_range(0, 3);
      mem_ready_in = (resp_cnt == lat);
      resp_cnt++;
    end else begin
      mem_ready_in = late_ready;
      resp_cnt = 0;
    end
    mem_rdata_in = mem_ready_in ? mem_word(mem_addr_out) : $urandom();
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    respond();
    model_step();
    @(posedge clk_in);
    #1;
    chk("mem_req", mem_req_out, e_mreq);
    chk("mem_addr", mem_addr_out, e_maddr);
    chk("mem_rw", mem_rw_out, e_mrw);
    chk("mem_size", mem_access_size_out, e_msize);
    chk("mem_wdata", mem_wdata_out, e_mwdata);
    chk("f_done", f_done_out, e_fdone);
    chk("f_rdata", f_rdata_out, e_frd);
    chk("d_done", d_done_out, e_ddone);
    chk("d_rdata", d_rdata_out, e_drd);
    chk("err", err_out, m_err);
    chk("err_code", err_code_out, m_code);
    chk("stall", stall_fetch_out, f_req_in & ~e_fdone);
    chk("no_dual_done", f_done_out & d_done_out, 1'b0);
    if (mem_req_out && !prev_mreq) glog.push_back(mem_addr_out >= 32'h8003_0000);
    prev_mreq = mem_req_out;
    if (mem_req_out) mreq_cycles++;
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset_n_in = 0; f_req_in = 0; d_req_in = 0;
    hang = 0; late_ready = 0;
    model_reset();
    tick();
    tick();
    reset_n_in = 1;
  endtask

  task automatic wait_done(input bit is_f, input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(is_f ? f_done_out : d_done_out) && n < bound);
    chk(is_f ? "f_done_seen" : "d_done_seen", is_f ? f_done_out : d_done_out, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    bit fa, da;
    string exp_seq;
    logic [31:0] a;

    reset_n_in = 0; f_req_in = 0; d_req_in = 0; f_addr_in = '0;
    d_addr_in = '0; d_rw_in = 0; d_access_size_in = '0; d_wdata_in = '0;
    mem_ready_in = 0; mem_rdata_in = '0;
    @(negedge clk_in);
    #1;
    chk("reset_mem_req", mem_req_out, 1'b0);
    chk("reset_err", {err_out, err_code_out}, 3'b000);
    @(negedge clk_in);
    do_reset();

    // vector table: single transaction legality and data return
    vecs[0]  = '{1'b1, 32'h8002_0000, 1'b0, 2'b10, 1'b1, 2'b00};
    vecs[1]  = '{1'b1, 32'h8002_0010, 1'b0, 2'b10, 1'b1, 2'b00};
    vecs[2]  = '{1'b1, 32'h8001_FFFC, 1'b0, 2'b10, 1'b0, 2'b10};
    vecs[3]  = '{1'b1, 32'h8002_0002, 1'b0, 2'b10, 1'b0, 2'b10};
    vecs[4]  = '{1'b0, 32'h8003_0004, 1'b0, 2'b10, 1'b1, 2'b00};
    vecs[5]  = '{1'b0, 32'h8003_0002, 1'b0, 2'b01, 1'b1, 2'b00};
    vecs[6]  = '{1'b0, 32'h8003_0003, 1'b1, 2'b00, 1'b1, 2'b00};
    vecs[7]  = '{1'b0, 32'h8003_0003, 1'b1, 2'b01, 1'b0, 2'b10};
    vecs[8]  = '{1'b0, 32'h8003_0006, 1'b0, 2'b10, 1'b0, 2'b10};
    vecs[9]  = '{1'b0, 32'h8003_0000, 1'b0, 2'b11, 1'b0, 2'b11};
    vecs[10] = '{1'b0, 32'h8003_0008, 1'b1, 2'b10, 1'b1, 2'b00};
    for (int i = 0; i < 11; i++) begin
      do_reset();
      lat = 1;
      mreq_cycles = 0;
      if (vecs[i].is_f) begin
        f_addr_in = vecs[i].addr; f_req_in = 1;
      end else begin
        d_addr_in = vecs[i].addr; d_rw_in = vecs[i].rw;
        d_access_size_in = vecs[i].size; d_wdata_in = $urandom(); d_req_in = 1;
      end
      wait_done(vecs[i].is_f, 20, n);
      chk($sformatf("vec%0d_issued", i), mreq_cycles > 0, vecs[i].exp_issue);
      chk($sformatf("vec%0d_err", i), err_out, vecs[i].exp_code != 2'b00);
      chk($sformatf("vec%0d_code", i), err_code_out, vecs[i].exp_code);
      chk($sformatf("vec%0d_rdata", i), vecs[i].is_f ? f_rdata_out : d_rdata_out,
          (vecs[i].exp_issue && !vecs[i].rw) ? mem_word(vecs[i].addr) : 32'h0);
      f_req_in = 0; d_req_in = 0;
      tick();
    end

    // fetch only, ready two cycles after mem_req rises
    do_reset();
    lat = 2;
    f_addr_in = 32'h8002_0000; f_req_in = 1;
    tick();
    chk("fetch_mem_req", mem_req_out, 1'b1);
    chk("fetch_mem_addr", mem_addr_out, 32'h8002_0000);
    chk("fetch_mem_size", mem_access_size_out, 2'b10);
    chk("fetch_mem_rw", mem_rw_out, 1'b0);
    chk("fetch_stall_pending", stall_fetch_out, 1'b1);
    wait_done(1, 20, n);
    chk("fetch_latency", n + 1, 4);
    chk("fetch_stall_done", stall_fetch_out, 1'b0);
    chk("fetch_rdata", f_rdata_out, mem_word(32'h8002_0000));
    f_req_in = 0;
    tick();

    // simultaneous requests: data first, fetch right after
    do_reset();
    lat = 1;
    glog.delete();
    f_addr_in = 32'h8002_0040; f_req_in = 1;
    d_addr_in = 32'h8003_0004; d_rw_in = 0; d_access_size_in = 2'b10; d_req_in = 1;
    wait_done(0, 20, n);
    chk("sim_first_grant_data", (glog.size() == 1) ? glog[0] : 1'b0, 1'b1);
    chk("sim_no_fdone_with_ddone", f_done_out, 1'b0);
    chk("sim_d_rdata", d_rdata_out, mem_word(32'h8003_0004));
    d_req_in = 0;
    tick();
    chk("sim_fetch_granted_next", mem_req_out && (mem_addr_out == 32'h8002_0040), 1'b1);
    wait_done(1, 20, n);
    chk("sim_f_rdata", f_rdata_out, mem_word(32'h8002_0040));
    f_req_in = 0;
    tick();

    // anti-starvation: fetch held, data back-to-back
    do_reset();
    lat = 0;
    glog.delete();
    f_addr_in = 32'h8002_0100; f_req_in = 1;
    d_addr_in = 32'h8003_0000; d_rw_in = 0; d_access_size_in = 2'b10; d_req_in = 1;
    n = 0;
    while (glog.size() < 11 && n < 80) begin
      tick();
      n++;
    end
    chk("streak_grant_count", glog.size(), 11);
    exp_seq = "DDDDFDDDDFD";
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("streak_grant%0d", i), (i < glog.size()) ? glog[i] : 1'bx,
          exp_seq[i] == "D");
    end
    f_req_in = 0; d_req_in = 0;
    repeat (3) tick();

    // misaligned halfword store never reaches memory
    do_reset();
    lat = 1;
    mreq_cycles = 0;
    d_addr_in = 32'h8003_0003; d_rw_in = 1; d_access_size_in = 2'b01;
    d_wdata_in = 32'hCAFE_F00D; d_req_in = 1;
    tick();
    chk("mis_d_done", d_done_out, 1'b1);
    chk("mis_no_mem_req", mem_req_out, 1'b0);
    chk("mis_err", err_out, 1'b1);
    chk("mis_code", err_code_out, 2'b10);
    d_req_in = 0;
    f_addr_in = 32'h8002_0200; f_req_in = 1;
    wait_done(1, 20, n);
    chk("mis_follow_fetch", f_rdata_out, mem_word(32'h8002_0200));
    chk("mis_code_sticky", err_code_out, 2'b10);
    f_req_in = 0;
    tick();

    // hung memory: watchdog abort, late ready ignored
    do_reset();
    hang = 1;
    mreq_cycles = 0;
    d_addr_in = 32'h8003_0010; d_rw_in = 0; d_access_size_in = 2'b10; d_req_in = 1;
    wait_done(0, 100, n);
    chk("to_busy_cycles", mreq_cycles, TIMEOUT);
    chk("to_mem_req_dropped", mem_req_out, 1'b0);
    chk("to_code", err_code_out, 2'b01);
    chk("to_rdata", d_rdata_out, 32'h0);
    d_req_in = 0; hang = 0;
    late_ready = 1;
    tick();
    late_ready = 0;
    chk("to_late_ready_ignored", {mem_req_out, f_done_out, d_done_out}, 3'b000);
    tick();

    // asynchronous reset in the middle of a data access
    do_reset();
    lat = 6;
    d_addr_in = 32'h8003_0020; d_rw_in = 0; d_access_size_in = 2'b10; d_req_in = 1;
    repeat (3) tick();
    chk("rst_mid_busy", mem_req_out, 1'b1);
    #2;
    reset_n_in = 0;
    #1;
    chk("rst_async_mem", {mem_req_out, mem_rw_out, mem_access_size_out}, 4'h0);
    chk("rst_async_addr", mem_addr_out | mem_wdata_out, 32'h0);
    chk("rst_async_done", {f_done_out, d_done_out, stall_fetch_out}, 3'b000);
    chk("rst_async_rdata", f_rdata_out | d_rdata_out, 32'h0);
    chk("rst_async_err", {err_out, err_code_out}, 3'b000);
    model_reset();
    d_req_in = 0;
    @(negedge clk_in);
    tick();
    reset_n_in = 1;
    repeat (4) begin
      tick();
      chk("rst_no_spurious_done", {f_done_out, d_done_out, mem_req_out}, 3'b000);
    end
    lat = 1;
    d_addr_in = 32'h8003_0024; d_req_in = 1;
    wait_done(0, 20, n);
    chk("rst_next_served", d_rdata_out, mem_word(32'h8003_0024));
    d_req_in = 0;
    tick();

    // randomized two-requester traffic against the model
    do_reset();
    rand_lat = 1;
    fa = 0; da = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (f_done_out) fa = 0;
      if (d_done_out) da = 0;
      if (!fa && $urandom_range(0, 2) == 0) begin
        fa = 1;
        if ($urandom_range(0, 15) == 0)
          f_addr_in = ($urandom_range(0, 1) == 0) ? IBASE - 32'd4 : IBASE + 32'd2;
        else
          f_addr_in = IBASE + 32'($urandom_range(0, 1023)) * 32'd4;
      end
      if (!da && $urandom_range(0, 2) == 0) begin
        da = 1;
        d_access_size_in = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        a = 32'h8003_0000 + 32'($urandom_range(0, 4095));
        if ($urandom_range(0, 7) != 0) begin
          if (d_access_size_in == 2'b10) a = a & ~32'd3;
          if (d_access_size_in == 2'b01) a = a & ~32'd1;
        end
        d_addr_in = a;
        d_rw_in = 1'($urandom_range(0, 1));
        d_wdata_in = $urandom();
      end
      f_req_in = fa;
      d_req_in = da;
      tick();
    end
    f_req_in = 0; d_req_in = 0;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
